// File: rtl/v_wb_arbiter.sv
// v_wb_arbiter
//   Shares the single vector register-file write port between the vector ALU
//   and the vector memory unit (vle32 load data). Each source pushes results
//   through a valid/ready handshake into its own small FIFO; a round-robin
//   arbiter drains one FIFO head per cycle into a registered write port.
//   A per-register pending mask is exported so issue logic can stall on
//   RAW/WAW hazards against writes that have not reached the register file.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   alu_valid_i / alu_ready_o   ALU result handshake
//   alu_addr_i / alu_data_i     ALU destination vreg and result
//   mem_valid_i / mem_ready_o   load result handshake
//   mem_addr_i / mem_data_i     load destination vreg and data
//   vwb_en_o                    register-file write enable (registered)
//   vwb_addr_o / vwb_data_o     write address / data (hold when idle)
//   pending_o                   bit k set while a write to vreg k is buffered
//                               or sitting in the output register

// v_wb_arbiter_fifo
//   Per-source result buffer. Circular storage with read/write pointers that
//   wrap modulo DEPTH and a separate occupancy count to tell full from empty.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   push_valid / push_ready     producer handshake (no accept while full)
//   push_addr / push_data       entry written at the tail
//   pop                         remove the head (ignored when empty)
//   empty                       no valid entries
//   head_addr / head_data       oldest entry
//   pending                     one-hot OR of all valid entry addresses
module v_wb_arbiter_fifo #(
  parameter int AW    = 5,
  parameter int DW    = 256,
  parameter int DEPTH = 2,
  parameter int NREG  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_valid,
  output logic            push_ready,
  input  logic [AW-1:0]   push_addr,
  input  logic [DW-1:0]   push_data,
  input  logic            pop,
  output logic            empty,
  output logic [AW-1:0]   head_addr,
  output logic [DW-1:0]   head_data,
  output logic [NREG-1:0] pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          push;
  logic          do_pop;
  logic [PW-1:0] offset;

  // A full FIFO never accepts, even when it pops in the same cycle, so the
  // ready path does not depend on the arbiter's grant.
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign push_ready = !rst && !full;
  assign push       = push_valid && push_ready;
  assign do_pop     = pop && !empty;
  assign head_addr  = addr_mem[rd_ptr];
  assign head_data  = data_mem[rd_ptr];

  // Storage is not reset; only entries covered by count are ever looked at.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A slot holds a live entry when its distance from the read pointer is
  // below the occupancy count.
  always_comb begin
    pending = '0;
    offset  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - rd_ptr;
      if (CW'(offset) < count) pending[addr_mem[i]] = 1'b1;
    end
  end

endmodule

module v_wb_arbiter #(
  parameter int VREG_AW    = 5,
  parameter int VREG_DW    = 256,
  parameter int NREG       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_valid_i,
  output logic               alu_ready_o,
  input  logic [VREG_AW-1:0] alu_addr_i,
  input  logic [VREG_DW-1:0] alu_data_i,
  input  logic               mem_valid_i,
  output logic               mem_ready_o,
  input  logic [VREG_AW-1:0] mem_addr_i,
  input  logic [VREG_DW-1:0] mem_data_i,
  output logic               vwb_en_o,
  output logic [VREG_AW-1:0] vwb_addr_o,
  output logic [VREG_DW-1:0] vwb_data_o,
  output logic [NREG-1:0]    pending_o
);

  typedef enum logic {GRANT_ALU, GRANT_MEM} grant_e;

  grant_e             last_grant;
  grant_e             last_grant_next;
  logic               grant_alu;
  logic               grant_mem;
  logic               alu_empty;
  logic               mem_empty;
  logic [VREG_AW-1:0] alu_head_addr;
  logic [VREG_DW-1:0] alu_head_data;
  logic [VREG_AW-1:0] mem_head_addr;
  logic [VREG_DW-1:0] mem_head_data;
  logic [NREG-1:0]    alu_pending;
  logic [NREG-1:0]    mem_pending;
  logic [NREG-1:0]    out_pending;

  v_wb_arbiter_fifo #(
    .AW(VREG_AW), .DW(VREG_DW), .DEPTH(FIFO_DEPTH), .NREG(NREG)
  ) u_alu_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (alu_valid_i),
    .push_ready (alu_ready_o),
    .push_addr  (alu_addr_i),
    .push_data  (alu_data_i),
    .pop        (grant_alu),
    .empty      (alu_empty),
    .head_addr  (alu_head_addr),
    .head_data  (alu_head_data),
    .pending    (alu_pending)
  );

  v_wb_arbiter_fifo #(
    .AW(VREG_AW), .DW(VREG_DW), .DEPTH(FIFO_DEPTH), .NREG(NREG)
  ) u_mem_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (mem_valid_i),
    .push_ready (mem_ready_o),
    .push_addr  (mem_addr_i),
    .push_data  (mem_data_i),
    .pop        (grant_mem),
    .empty      (mem_empty),
    .head_addr  (mem_head_addr),
    .head_data  (mem_head_data),
    .pending    (mem_pending)
  );

  // Round-robin state: remembers which source won most recently. Resetting
  // to ALU makes MEM win the first tie.
  always_ff @(posedge clk) begin
    if (rst) last_grant <= GRANT_ALU;
    else     last_grant <= last_grant_next;
  end

  // On a tie the source that did not win last time is granted; a lone
  // non-empty FIFO is always granted; with nothing buffered the round-robin
  // state is left alone.
  always_comb begin
    grant_alu       = 1'b0;
    grant_mem       = 1'b0;
    last_grant_next = last_grant;
    if (!alu_empty && !mem_empty) begin
      if (last_grant == GRANT_ALU) grant_mem = 1'b1;
      else                         grant_alu = 1'b1;
    end else if (!alu_empty) begin
      grant_alu = 1'b1;
    end else if (!mem_empty) begin
      grant_mem = 1'b1;
    end
    if (grant_alu) last_grant_next = GRANT_ALU;
    if (grant_mem) last_grant_next = GRANT_MEM;
  end

  // Registered write port. Address and data keep their last value on idle
  // cycles so only the enable toggles.
  always_ff @(posedge clk) begin
    if (rst) begin
      vwb_en_o   <= 1'b0;
      vwb_addr_o <= '0;
      vwb_data_o <= '0;
    end else begin
      vwb_en_o <= grant_alu || grant_mem;
      if (grant_alu) begin
        vwb_addr_o <= alu_head_addr;
        vwb_data_o <= alu_head_data;
      end else if (grant_mem) begin
        vwb_addr_o <= mem_head_addr;
        vwb_data_o <= mem_head_data;
      end
    end
  end

  // A write stays visible as pending until it has left the output register.
  assign out_pending = vwb_en_o ? (NREG'(1) << vwb_addr_o) : '0;
  assign pending_o   = alu_pending | mem_pending | out_pending;

endmodule

// File: tb/tb_v_wb_arbiter.sv
// tb_v_wb_arbiter
//   Self-checking bench for v_wb_arbiter. Directed scenarios use fixed
//   expected values; the randomized scenario runs against a queue-based
//   reference model of the two source buffers, the round-robin choice and
//   the output register.
module tb_v_wb_arbiter;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [4:0]   addr;
    logic [255:0] data;
  } entry_t;

  logic         clk;
  logic         rst;
  logic         alu_valid_i;
  logic         alu_ready_o;
  logic [4:0]   alu_addr_i;
  logic [255:0] alu_data_i;
  logic         mem_valid_i;
  logic         mem_ready_o;
  logic [4:0]   mem_addr_i;
  logic [255:0] mem_data_i;
  logic         vwb_en_o;
  logic [4:0]   vwb_addr_o;
  logic [255:0] vwb_data_o;
  logic [31:0]  pending_o;

  int checks = 0;
  int fails  = 0;

  // Reference model state.
  entry_t       aq[$];
  entry_t       mq[$];
  logic         m_en;
  logic [4:0]   m_addr;
  logic [255:0] m_data;
  logic         m_last_mem;
  logic         m_alu_acc;
  logic         m_mem_acc;

  v_wb_arbiter #(
    .VREG_AW(5), .VREG_DW(256), .NREG(32), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid_i (alu_valid_i),
    .alu_ready_o (alu_ready_o),
    .alu_addr_i  (alu_addr_i),
    .alu_data_i  (alu_data_i),
    .mem_valid_i (mem_valid_i),
    .mem_ready_o (mem_ready_o),
    .mem_addr_i  (mem_addr_i),
    .mem_data_i  (mem_data_i),
    .vwb_en_o    (vwb_en_o),
    .vwb_addr_o  (vwb_addr_o),
    .vwb_data_o  (vwb_data_o),
    .pending_o   (pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v = {v[223:0], 32'($urandom())};
    return v;
  endfunction

  function automatic logic [31:0] model_pending();
    logic [31:0] p;
    p = '0;
    foreach (aq[i]) p[aq[i].addr] = 1'b1;
    foreach (mq[i]) p[mq[i].addr] = 1'b1;
    if (m_en) p[m_addr] = 1'b1;
    return p;
  endfunction

  // Applies the rules for one rising edge to the model, using the inputs as
  // they stand at that edge.
  task automatic model_edge();
    entry_t w;
    logic ga, gm;
    m_alu_acc = 1'b0;
    m_mem_acc = 1'b0;
    if (rst) begin
      aq.delete();
      mq.delete();
      m_en       = 1'b0;
      m_addr     = '0;
      m_data     = '0;
      m_last_mem = 1'b0;
    end else begin
      m_alu_acc = alu_valid_i && (aq.size() < DEPTH);
      m_mem_acc = mem_valid_i && (mq.size() < DEPTH);
      ga = 1'b0;
      gm = 1'b0;
      if (aq.size() > 0 && mq.size() > 0) begin
        if (m_last_mem) ga = 1'b1;
        else            gm = 1'b1;
      end else if (aq.size() > 0) begin
        ga = 1'b1;
      end else if (mq.size() > 0) begin
        gm = 1'b1;
      end
      m_en = ga || gm;
      if (ga) begin
        w = aq.pop_front();
        m_addr = w.addr;
        m_data = w.data;
        m_last_mem = 1'b0;
      end
      if (gm) begin
        w = mq.pop_front();
        m_addr = w.addr;
        m_data = w.data;
        m_last_mem = 1'b1;
      end
      if (m_alu_acc) aq.push_back({alu_addr_i, alu_data_i});
      if (m_mem_acc) mq.push_back({mem_addr_i, mem_data_i});
    end
  endtask

  // Drives one cycle of inputs, advances through the rising edge and the
  // model, and returns 1 time unit after the edge.
  task automatic tick(input logic r,
                      input logic av, input logic [4:0] aa, input logic [255:0] ad,
                      input logic mv, input logic [4:0] ma, input logic [255:0] md);
    rst         = r;
    alu_valid_i = av;
    alu_addr_i  = aa;
    alu_data_i  = ad;
    mem_valid_i = mv;
    mem_addr_i  = ma;
    mem_data_i  = md;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
    checks++; if (vwb_en_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_en: got %b expected 0", vwb_en_o); end
    checks++; if (vwb_addr_o !== 5'd0) begin fails++; $display("[TB] FAIL reset_addr: got %0d expected 0", vwb_addr_o); end
    checks++; if (vwb_data_o !== 256'd0) begin fails++; $display("[TB] FAIL reset_data: got %h expected 0", vwb_data_o); end
    checks++; if (pending_o !== 32'd0) begin fails++; $display("[TB] FAIL reset_pending: got %h expected 0", pending_o); end
    checks++; if ({alu_ready_o, mem_ready_o} !== 2'b00) begin fails++; $display("[TB] FAIL reset_ready_in_reset: got %b expected 00", {alu_ready_o, mem_ready_o}); end
    idle();
    checks++; if ({alu_ready_o, mem_ready_o} !== 2'b11) begin fails++; $display("[TB] FAIL reset_ready_after: got %b expected 11", {alu_ready_o, mem_ready_o}); end
    checks++; if (vwb_en_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_no_write: got %b expected 0", vwb_en_o); end
  endtask

  task automatic test_single_alu();
    logic [255:0] pat;
    pat = {32{8'hA5}};
    do_reset();
    tick(1'b0, 1'b1, 5'd3, pat, 1'b0, 5'd0, '0);
    checks++; if (vwb_en_o !== 1'b0) begin fails++; $display("[TB] FAIL single_en_c2: got %b expected 0", vwb_en_o); end
    checks++; if (pending_o !== 32'h8) begin fails++; $display("[TB] FAIL single_pending_c2: got %h expected 00000008", pending_o); end
    idle();
    checks++; if ({vwb_en_o, vwb_addr_o} !== {1'b1, 5'd3}) begin fails++; $display("[TB] FAIL single_write_c3: got en=%b addr=%0d expected en=1 addr=3", vwb_en_o, vwb_addr_o); end
    checks++; if (vwb_data_o !== pat) begin fails++; $display("[TB] FAIL single_data_c3: got %h expected %h", vwb_data_o, pat); end
    checks++; if (pending_o !== 32'h8) begin fails++; $display("[TB] FAIL single_pending_c3: got %h expected 00000008", pending_o); end
    idle();
    checks++; if (vwb_en_o !== 1'b0) begin fails++; $display("[TB] FAIL single_en_c4: got %b expected 0", vwb_en_o); end
    checks++; if (pending_o !== 32'h0) begin fails++; $display("[TB] FAIL single_pending_c4: got %h expected 0", pending_o); end
    checks++; if (vwb_addr_o !== 5'd3) begin fails++; $display("[TB] FAIL single_addr_hold: got %0d expected 3", vwb_addr_o); end
  endtask

  task automatic test_contention();
    do_reset();
    tick(1'b0, 1'b1, 5'd1, 256'h11, 1'b1, 5'd2, 256'h22);
    checks++; if (pending_o !== 32'h6) begin fails++; $display("[TB] FAIL cont_pending: got %h expected 00000006", pending_o); end
    idle();
    checks++; if ({vwb_en_o, vwb_addr_o, vwb_data_o} !== {1'b1, 5'd2, 256'h22}) begin fails++; $display("[TB] FAIL cont_first_mem: got en=%b addr=%0d expected en=1 addr=2", vwb_en_o, vwb_addr_o); end
    idle();
    checks++; if ({vwb_en_o, vwb_addr_o, vwb_data_o} !== {1'b1, 5'd1, 256'h11}) begin fails++; $display("[TB] FAIL cont_second_alu: got en=%b addr=%0d expected en=1 addr=1", vwb_en_o, vwb_addr_o); end
    idle();
    // Last winner was ALU, so the next tie goes to MEM again.
    tick(1'b0, 1'b1, 5'd10, 256'h10, 1'b1, 5'd11, 256'h11);
    idle();
    checks++; if ({vwb_en_o, vwb_addr_o} !== {1'b1, 5'd11}) begin fails++; $display("[TB] FAIL cont_next_tie_mem: got en=%b addr=%0d expected en=1 addr=11", vwb_en_o, vwb_addr_o); end
    idle();
    checks++; if ({vwb_en_o, vwb_addr_o} !== {1'b1, 5'd10}) begin fails++; $display("[TB] FAIL cont_next_tie_alu: got en=%b addr=%0d expected en=1 addr=10", vwb_en_o, vwb_addr_o); end
    idle();
  endtask

  task automatic test_backpressure();
    int ai, mi;
    logic saw_block;
    int mem_seen[$];
    int alu_seen[$];
    ai = 0;
    mi = 0;
    saw_block = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick(1'b0, ai < 6, 5'(16 + ai), 256'(ai + 100), mi < 4, 5'(4 + mi), 256'(mi + 200));
      if (m_alu_acc) ai++;
      if (m_mem_acc) mi++;
      checks++; if ({vwb_en_o, vwb_addr_o, vwb_data_o} !== {m_en, m_addr, m_data}) begin fails++; $display("[TB] FAIL bp_write: got en=%b addr=%0d expected en=%b addr=%0d", vwb_en_o, vwb_addr_o, m_en, m_addr); end
      checks++; if (mem_ready_o !== (mq.size() < DEPTH)) begin fails++; $display("[TB] FAIL bp_mem_ready: got %b expected %b", mem_ready_o, mq.size() < DEPTH); end
      if (!mem_ready_o) saw_block = 1'b1;
      if (vwb_en_o) begin
        if (vwb_addr_o >= 5'd4 && vwb_addr_o <= 5'd7) mem_seen.push_back(int'(vwb_addr_o));
        else alu_seen.push_back(int'(vwb_addr_o));
      end
    end
    checks++; if (saw_block !== 1'b1) begin fails++; $display("[TB] FAIL bp_ready_dropped: got %b expected 1", saw_block); end
    checks++; if (mem_seen.size() != 4) begin fails++; $display("[TB] FAIL bp_mem_count: got %0d expected 4", mem_seen.size()); end
    checks++; if (alu_seen.size() != 6) begin fails++; $display("[TB] FAIL bp_alu_count: got %0d expected 6", alu_seen.size()); end
    foreach (mem_seen[i]) begin
      checks++; if (mem_seen[i] != 4 + i) begin fails++; $display("[TB] FAIL bp_mem_order: got %0d expected %0d", mem_seen[i], 4 + i); end
    end
  endtask

  task automatic test_full_pop();
    int n21, n22;
    n21 = 0;
    n22 = 0;
    do_reset();
    tick(1'b0, 1'b1, 5'd20, 256'h20, 1'b1, 5'd24, 256'h24);
    tick(1'b0, 1'b1, 5'd21, 256'h21, 1'b1, 5'd25, 256'h25);
    checks++; if (alu_ready_o !== 1'b0) begin fails++; $display("[TB] FAIL full_ready_low: got %b expected 0", alu_ready_o); end
    checks++; if ({vwb_en_o, vwb_addr_o} !== {1'b1, 5'd24}) begin fails++; $display("[TB] FAIL full_first_write: got en=%b addr=%0d expected en=1 addr=24", vwb_en_o, vwb_addr_o); end
    tick(1'b0, 1'b1, 5'd22, 256'h22, 1'b0, 5'd0, '0);
    checks++; if (alu_ready_o !== 1'b1) begin fails++; $display("[TB] FAIL full_ready_after_pop: got %b expected 1", alu_ready_o); end
    checks++; if ({vwb_en_o, vwb_addr_o} !== {1'b1, 5'd20}) begin fails++; $display("[TB] FAIL full_pop_write: got en=%b addr=%0d expected en=1 addr=20", vwb_en_o, vwb_addr_o); end
    tick(1'b0, 1'b1, 5'd22, 256'h22, 1'b0, 5'd0, '0);
    for (int i = 0; i < 5; i++) begin
      if (vwb_en_o && vwb_addr_o == 5'd21) n21++;
      if (vwb_en_o && vwb_addr_o == 5'd22) n22++;
      idle();
    end
    checks++; if (n21 != 1) begin fails++; $display("[TB] FAIL full_a1_once: got %0d expected 1", n21); end
    checks++; if (n22 != 1) begin fails++; $display("[TB] FAIL full_a2_once: got %0d expected 1", n22); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(1'b0, 1'b1, 5'd12, 256'h12, 1'b1, 5'd13, 256'h13);
    tick(1'b0, 1'b1, 5'd14, 256'h14, 1'b1, 5'd15, 256'h15);
    tick(1'b1, 1'b1, 5'd16, 256'h16, 1'b1, 5'd17, 256'h17);
    checks++; if (vwb_en_o !== 1'b0) begin fails++; $display("[TB] FAIL mid_en: got %b expected 0", vwb_en_o); end
    checks++; if (pending_o !== 32'd0) begin fails++; $display("[TB] FAIL mid_pending: got %h expected 0", pending_o); end
    rst = 1'b0;
    alu_valid_i = 1'b0;
    mem_valid_i = 1'b0;
    #1;
    checks++; if ({alu_ready_o, mem_ready_o} !== 2'b11) begin fails++; $display("[TB] FAIL mid_ready: got %b expected 11", {alu_ready_o, mem_ready_o}); end
    for (int i = 0; i < 4; i++) begin
      idle();
      checks++; if ({vwb_en_o, pending_o} !== {1'b0, 32'd0}) begin fails++; $display("[TB] FAIL mid_stale: got en=%b pending=%h expected en=0 pending=0", vwb_en_o, pending_o); end
    end
  endtask

  task automatic test_pending_overlap();
    do_reset();
    tick(1'b0, 1'b1, 5'd9, 256'h91, 1'b1, 5'd9, 256'h92);
    checks++; if (pending_o !== 32'h200) begin fails++; $display("[TB] FAIL ovl_buffered: got %h expected 00000200", pending_o); end
    idle();
    checks++; if ({vwb_en_o, vwb_data_o, pending_o} !== {1'b1, 256'h92, 32'h200}) begin fails++; $display("[TB] FAIL ovl_first_out: got en=%b pending=%h expected en=1 pending=00000200", vwb_en_o, pending_o); end
    idle();
    checks++; if ({vwb_en_o, vwb_data_o, pending_o} !== {1'b1, 256'h91, 32'h200}) begin fails++; $display("[TB] FAIL ovl_second_out: got en=%b pending=%h expected en=1 pending=00000200", vwb_en_o, pending_o); end
    idle();
    checks++; if (pending_o !== 32'd0) begin fails++; $display("[TB] FAIL ovl_cleared: got %h expected 0", pending_o); end
  endtask

  task automatic test_random();
    logic av, mv, r;
    entry_t a_item, m_item;
    av = 1'b0;
    mv = 1'b0;
    a_item = {5'(($urandom())), rand256()};
    m_item = {5'(($urandom())), rand256()};
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      r = ($urandom_range(0, 59) == 0);
      tick(r, av, a_item.addr, a_item.data, mv, m_item.addr, m_item.data);
      checks++; if ({vwb_en_o, vwb_addr_o, vwb_data_o} !== {m_en, m_addr, m_data}) begin fails++; $display("[TB] FAIL rand_write cyc=%0d: got en=%b addr=%0d expected en=%b addr=%0d", cyc, vwb_en_o, vwb_addr_o, m_en, m_addr); end
      checks++; if (pending_o !== model_pending()) begin fails++; $display("[TB] FAIL rand_pending cyc=%0d: got %h expected %h", cyc, pending_o, model_pending()); end
      checks++; if ({alu_ready_o, mem_ready_o} !== {!rst && aq.size() < DEPTH, !rst && mq.size() < DEPTH}) begin fails++; $display("[TB] FAIL rand_ready cyc=%0d: got %b%b expected %b%b", cyc, alu_ready_o, mem_ready_o, !rst && aq.size() < DEPTH, !rst && mq.size() < DEPTH); end
      // Producers hold an offered item until it is taken.
      if (m_alu_acc || !av) begin
        av = ($urandom_range(0, 3) != 0);
        a_item = {5'(($urandom())), rand256()};
      end
      if (m_mem_acc || !mv) begin
        mv = ($urandom_range(0, 2) != 0);
        m_item = {5'(($urandom())), rand256()};
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    alu_valid_i = 1'b0;
    alu_addr_i = '0;
    alu_data_i = '0;
    mem_valid_i = 1'b0;
    mem_addr_i = '0;
    mem_data_i = '0;
    m_en = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_last_mem = 1'b0;
    m_alu_acc = 1'b0;
    m_mem_acc = 1'b0;
    test_reset();
    test_single_alu();
    test_contention();
    test_backpressure();
    test_full_pop();
    test_reset_mid();
    test_pending_overlap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
